// File: rtl/signmag_pkg.sv
// signmag_pkg: shared FSM states, default width and requester index type for the sign-magnitude arbiter
package signmag_pkg;
    localparam int DEFAULT_BITS = 8;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} stateType;
    typedef logic reqIdx;
endpackage

// File: rtl/signmag_addsub_core.sv
// signmag_addsub_core: combinational sign-magnitude add/sub in a widened two's-complement domain; SIGNMAG_SAT_EN saturates on overflow, otherwise wraps
module signmag_addsub_core
    import signmag_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            sign_a,
    input  logic            sign_b,
    input  logic            sub,
    output logic [BITS-1:0] magnitude,
    output logic            sign,
    output logic            overflow
);
    localparam int W = BITS + 2;

    logic [W-1:0] opA, opB, sum, absSum;

    assign opA = sign_a ? -{2'b00, a} : {2'b00, a};
    assign opB = (sign_b ^ sub) ? -{2'b00, b} : {2'b00, b};
    assign sum = opA + opB;
    assign absSum = sum[W-1] ? -sum : sum;
    assign overflow = |absSum[W-1:BITS];
`ifdef SIGNMAG_SAT_EN
    assign magnitude = overflow ? '1 : absSum[BITS-1:0];
`else
    assign magnitude = absSum[BITS-1:0];
`endif
    assign sign = sum[W-1] && (magnitude != '0);
endmodule

// File: rtl/signmag_arbiter.sv
// signmag_arbiter: round-robin arbiter sharing one sign-magnitude add/sub core between two requesters (SIGNMAG_SAT_EN enables saturation)
module signmag_arbiter
    import signmag_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0,
    input  logic            req1,
    input  logic [BITS-1:0] a0,
    input  logic [BITS-1:0] b0,
    input  logic [BITS-1:0] a1,
    input  logic [BITS-1:0] b1,
    input  logic            sign_a0,
    input  logic            sign_b0,
    input  logic            sign_a1,
    input  logic            sign_b1,
    input  logic            sub0,
    input  logic            sub1,
    output logic            grant0,
    output logic            grant1,
    output logic            busy,
    output logic            done0,
    output logic            done1,
    output logic [BITS-1:0] result,
    output logic            sign,
    output logic            overflow
);
    stateType state, nextState;
    reqIdx lastWinner, pick;
    logic [BITS-1:0] opA, opB, coreMag;
    logic opSignA, opSignB, opSub, coreSign, coreOverflow;

    signmag_addsub_core #(.BITS(BITS)) core (
        .a(opA),
        .b(opB),
        .sign_a(opSignA),
        .sign_b(opSignB),
        .sub(opSub),
        .magnitude(coreMag),
        .sign(coreSign),
        .overflow(coreOverflow)
    );

    assign busy = (state != IDLE);

    // tie goes to the requester not granted last; next state follows IDLE -> EXEC -> DONE
    always_comb begin
        pick = (req0 && req1) ? ~lastWinner : req1;
        nextState = (state == IDLE) ? ((req0 || req1) ? EXEC : IDLE) : (state == EXEC) ? DONE : IDLE;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nextState;
    end

    // operand capture, result registration and grant/done sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            result <= '0;
            sign <= 1'b0;
            overflow <= 1'b0;
            lastWinner <= 1'b1;
            opA <= '0;
            opB <= '0;
            opSignA <= 1'b0;
            opSignB <= 1'b0;
            opSub <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    grant0 <= !pick;
                    grant1 <= pick;
                    opA <= pick ? a1 : a0;
                    opB <= pick ? b1 : b0;
                    opSignA <= pick ? sign_a1 : sign_a0;
                    opSignB <= pick ? sign_b1 : sign_b0;
                    opSub <= pick ? sub1 : sub0;
                end
                EXEC: begin
                    result <= coreMag;
                    sign <= coreSign;
                    overflow <= coreOverflow;
                    done0 <= grant0;
                    done1 <= grant1;
                end
                DONE: begin
                    grant0 <= 1'b0;
                    grant1 <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    lastWinner <= grant1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/signmag_arbiter.md
# signmag_arbiter

Round-robin arbiter and sequencer that shares one sign-magnitude add/subtract datapath between two requesters. It captures the winning requester's operands, computes in a widened two's-complement domain, and returns a registered sign-magnitude result with an overflow flag and a one-cycle done pulse. It sits between the lab's arithmetic clients, such as the display and accumulator logic, and the shared arithmetic core.

## Interface
Parameters:
- BITS, 8, operand and result magnitude width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- req0, req1  in  1  operation request per requester; hold high until the matching done
- a0, b0, a1, b1  in  BITS  operand magnitudes per requester
- sign_a0, sign_b0, sign_a1, sign_b1  in  1  operand signs (1 = negative)
- sub0, sub1  in  1  operation select: 1 = a−b, 0 = a+b
- grant0, grant1  out  1  high while that requester's operation is in flight; one-hot or zero
- busy  out  1  high in any state other than IDLE
- done0, done1  out  1  one-cycle pulse; result is valid in the same cycle
- result  out  BITS  result magnitude; held until the next EXEC
- sign  out  1  result sign; never 1 when result is 0
- overflow  out  1  true result magnitude exceeds 2^BITS−1; held with result

## Operation
- FSM has three states: IDLE, EXEC and DONE.
- **IDLE**
  - At each edge with req0 or req1 high, pick the winner, latch its a, b, signs and sub into operand registers, set grant of the winner, and go to EXEC.
  - Tie: the requester not granted last time wins.
  - req is sampled only in IDLE.
- **EXEC**
  - The core result is registered into result/sign/overflow. Go to DONE.
- **DONE**
  - done of the winner is high for this cycle.
  - Next edge: clear grant and done, record the winner as last, go to IDLE.
- **Arithmetic**
  - Convert each operand to BITS+2 two's complement.
  - b's sign is inverted when sub=1.
  - Add, then convert back to sign and magnitude.
  - overflow = magnitude ≥ 2^BITS.
  - A zero magnitude forces sign=0, which removes negative zero.
- **Hold and reset**
  - Operand registers ignore input changes after capture.
  - Reset in any state aborts the operation, and no done is issued.
  - Reset values: state IDLE; grant0/1, done0/1, busy, result, sign and overflow all 0; last-winner = 1, so req0 wins the first tie.

## Timing
- Request seen at edge N. At N: grant and busy rise. At N+1: result registered. Between N+1 and N+2: done is high. At N+2: back in IDLE.
- Throughput is one operation per 3 cycles.
- A requester that holds req high through done is re-arbitrated at the following IDLE edge. If the other requester is waiting, the other requester wins.
- Outputs are registered only; there is no combinational path from req to grant or done.

## Configuration
- SIGNMAG_SAT_EN defined: on overflow, result = all ones (2^BITS−1) and sign is kept.
- Not defined: on overflow, result = low BITS of the true magnitude (wrap).
- overflow is asserted identically in both builds.

## Structure
- **Package signmag_pkg**
  - FSM state enum (IDLE, EXEC, DONE).
  - Default BITS constant.
  - Requester index type.
- **Sub-module signmag_addsub_core** (combinational, parameter BITS)
  - Inputs: a, b, sign_a, sign_b, sub.
  - Outputs: magnitude, sign, overflow, with saturation handled per the macro.
- The arbiter instantiates signmag_addsub_core once, on the operand registers.

## Test plan
1. **Reset:** rst pulsed mid-EXEC → all outputs 0 immediately; no done follows; busy 0.
2. **Single subtract, positive result:** req0 with a0=5+, b0=3+, sub0=1 → grant0 at N, done0 in cycle N+1..N+2, result=2, sign=0, overflow=0.
3. **Single subtract, negative result:** req1 with a1=3+, b1=5+, sub1=1 → done1 pulse, result=2, sign=1.
4. **Contention:** req0 and req1 raised together and held; op0 = 10− + 4+, op1 = 7+ − 2− → grant0 first, result=6 sign=1; then grant1, result=9 sign=0. Alternation continues while both stay high.
5. **Overflow (BITS=8):** 200+ + 100+ → overflow=1, sign=0, result=255 with SIGNMAG_SAT_EN, 44 without.
6. **Negative zero:** 7− − 7− → result=0, sign=0, overflow=0.
